// File: rtl/security_access_ctrl.sv
// Key-gated scramble/descramble engine shared by a memory-side and a register-side
// requester, with round-robin grant, one request in flight and bad-key lockout.
module security_access_ctrl #(
  parameter logic [15:0] KEY         = 16'h0032,
  parameter int          EXEC_CYCLES = 2,
  parameter int          MAX_FAIL    = 3,
  parameter int          LOCK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_valid,
  input  logic [31:0] mem_req_data,
  input  logic [15:0] mem_req_key,
  output logic        mem_req_ready,
  input  logic        reg_req_valid,
  input  logic [31:0] reg_req_data,
  input  logic [15:0] reg_req_key,
  output logic        reg_req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_src,
  output logic        rsp_err,
  output logic        locked,
  output logic [2:0]  fail_count
);

  localparam int CNT_W = 16;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_LOCK  = 3'd4;
  localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [2:0] FAIL_MAX = 3'(MAX_FAIL);

  function automatic logic [31:0] scramble(input logic [31:0] d);
    logic [31:0] t;
    t = (d - 32'd3) ^ 32'd2;
    t = t + 32'd9;
    return t * 32'd3;
  endfunction

  function automatic logic [31:0] descramble(input logic [31:0] d);
    logic [31:0] t;
    t = d / 32'd3;
    t = (t - 32'd9) ^ 32'd2;
    return (~t) + 32'd3;
  endfunction

  logic [2:0]       state_r;
  logic             last_grant_r;
  logic             src_r;
  logic [31:0]      data_r;
  logic [15:0]      key_r;
  logic [CNT_W-1:0] cnt_r;
  logic             rsp_valid_r;
  logic [31:0]      rsp_data_r;
  logic             rsp_src_r;
  logic             rsp_err_r;
  logic             locked_r;
  logic [2:0]       fail_count_r;
  logic             grant_reg_s;
  logic             mem_ready_s;
  logic             reg_ready_s;

  // Round-robin grant: on a tie the side opposite the previous grant wins.
  always_comb begin
    grant_reg_s = 1'b0;
    if (mem_req_valid && reg_req_valid) begin
      grant_reg_s = ~last_grant_r;
    end else if (reg_req_valid) begin
      grant_reg_s = 1'b1;
    end else begin
      grant_reg_s = 1'b0;
    end
  end

  assign mem_ready_s   = (state_r == ST_IDLE) && mem_req_valid && !grant_reg_s;
  assign reg_ready_s   = (state_r == ST_IDLE) && reg_req_valid && grant_reg_s;
  assign mem_req_ready = mem_ready_s;
  assign reg_req_ready = reg_ready_s;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_data      = rsp_data_r;
  assign rsp_src       = rsp_src_r;
  assign rsp_err       = rsp_err_r;
  assign locked        = locked_r;
  assign fail_count    = fail_count_r;

  // Request FSM, shared EXEC/LOCK down-counter and registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      src_r        <= 1'b0;
      data_r       <= 32'd0;
      key_r        <= 16'd0;
      cnt_r        <= '0;
      rsp_valid_r  <= 1'b0;
      rsp_data_r   <= 32'd0;
      rsp_src_r    <= 1'b0;
      rsp_err_r    <= 1'b0;
      locked_r     <= 1'b0;
      fail_count_r <= 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mem_ready_s || reg_ready_s) begin
            data_r       <= grant_reg_s ? reg_req_data : mem_req_data;
            key_r        <= grant_reg_s ? reg_req_key : mem_req_key;
            src_r        <= grant_reg_s;
            last_grant_r <= grant_reg_s;
            state_r      <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (key_r == KEY) begin
            fail_count_r <= 3'd0;
            rsp_err_r    <= 1'b0;
            cnt_r        <= EXEC_LOAD;
            state_r      <= ST_EXEC;
          end else begin
            if (fail_count_r != FAIL_MAX) begin
              fail_count_r <= fail_count_r + 3'd1;
            end
            rsp_err_r   <= 1'b1;
            rsp_data_r  <= 32'd0;
            rsp_src_r   <= src_r;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end
        end
        ST_EXEC: begin
          if (cnt_r == '0) begin
            rsp_data_r  <= src_r ? descramble(data_r) : scramble(data_r);
            rsp_src_r   <= src_r;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            if (fail_count_r == FAIL_MAX) begin
              locked_r <= 1'b1;
              cnt_r    <= LOCK_LOAD;
              state_r  <= ST_LOCK;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        ST_LOCK: begin
          if (cnt_r == '0) begin
            locked_r     <= 1'b0;
            fail_count_r <= 3'd0;
            state_r      <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          rsp_valid_r <= 1'b0;
          locked_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_security_access_ctrl.sv
// Scoreboard bench for security_access_ctrl: stimulus pushes expected responses,
// a negedge monitor pops and compares them on every response handshake.
module tb_security_access_ctrl;

  localparam logic [15:0] KEY = 16'h0032;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid, reg_req_valid, mem_req_ready, reg_req_ready;
  logic [31:0] mem_req_data, reg_req_data, rsp_data;
  logic [15:0] mem_req_key, reg_req_key;
  logic        rsp_valid, rsp_ready, rsp_src, rsp_err, locked;
  logic [2:0]  fail_count;

  security_access_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_data(mem_req_data),
    .mem_req_key(mem_req_key), .mem_req_ready(mem_req_ready),
    .reg_req_valid(reg_req_valid), .reg_req_data(reg_req_data),
    .reg_req_key(reg_req_key), .reg_req_ready(reg_req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_src(rsp_src), .rsp_err(rsp_err), .locked(locked), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        src;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Response monitor: one pop per handshake, seen just before the consuming edge.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual=%0h expected=none", rsp_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_data", rsp_data, mon_e.data);
        check("rsp_src", 32'(rsp_src), 32'(mon_e.src));
        check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
      end
    end
  end

  task automatic push(input bit side, input bit err, input logic [31:0] data);
    exp_t e;
    e.src = side; e.err = err; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit side, input logic [31:0] d, input logic [15:0] k);
    if (side) begin
      reg_req_valid = 1'b1; reg_req_data = d; reg_req_key = k;
    end else begin
      mem_req_valid = 1'b1; mem_req_data = d; mem_req_key = k;
    end
  endtask

  task automatic release_side(input bit side);
    if (side) reg_req_valid = 1'b0;
    else mem_req_valid = 1'b0;
  endtask

  // Entered at a negedge; returns at posedge+1 of the cycle after acceptance.
  task automatic wait_accept(input bit side);
    int n = 0;
    while (((side ? reg_req_ready : mem_req_ready) == 1'b0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL accept_timeout actual=%0d expected=<40", n);
    end
    @(posedge clk); #1;
    release_side(side);
  endtask

  // Counts cycles from acceptance (T) until rsp_valid is first seen.
  task automatic wait_rsp(input string name, input int exp_lat);
    int lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check(name, 32'(lat), 32'(exp_lat));
  endtask

  task automatic do_req(input bit side, input logic [31:0] d, input logic [15:0] k,
                        input logic [31:0] exp_data, input bit exp_err, input int exp_lat,
                        input string name);
    push(side, exp_err, exp_data);
    drive(side, d, k);
    @(negedge clk);
    wait_accept(side);
    wait_rsp(name, exp_lat);
    @(posedge clk); #1;
  endtask

  // Both sides request together; mem is expected to win the tie.
  task automatic tie_round(input string name);
    bit order[$];
    bit m, r;
    int n = 0;
    push(1'b0, 1'b0, 32'd42);
    push(1'b1, 1'b0, 32'hFFFF_FFFF);
    drive(1'b0, 32'd10, KEY);
    drive(1'b1, 32'd30, KEY);
    while ((mem_req_valid || reg_req_valid) && n < 60) begin
      @(negedge clk);
      m = mem_req_ready;
      r = reg_req_ready;
      if (m || r) order.push_back(r);
      @(posedge clk); #1;
      if (m) release_side(1'b0);
      if (r) release_side(1'b1);
      n++;
    end
    check({name, "_grants"}, 32'(order.size()), 32'd2);
    if (order.size() == 2) begin
      check({name, "_first"}, 32'(order[0]), 32'd0);
      check({name, "_second"}, 32'(order[1]), 32'd1);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int rdy;
    rst = 1'b1;
    mem_req_valid = 1'b0; mem_req_data = 32'd0; mem_req_key = 16'd0;
    reg_req_valid = 1'b0; reg_req_data = 32'd0; reg_req_key = 16'd0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_fail_count", 32'(fail_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1/T2: basic scramble and descramble, including wrap cases
    do_req(1'b0, 32'd10, KEY, 32'd42, 1'b0, 4, "t1_lat");
    do_req(1'b1, 32'd30, KEY, 32'hFFFF_FFFF, 1'b0, 4, "t2_reg_lat");
    do_req(1'b0, 32'd0, KEY, 32'd24, 1'b0, 4, "t2_wrap_lat");
    do_req(1'b1, 32'd0, KEY, 32'd13, 1'b0, 4, "t2_reg0_lat");
    do_req(1'b0, 32'd3, KEY, 32'd33, 1'b0, 4, "t2_mem3_lat");
    do_req(1'b1, 32'd100, KEY, 32'hFFFF_FFE8, 1'b0, 4, "t2_reg100_lat");

    // T3: simultaneous requests alternate grants
    tie_round("t3a");
    tie_round("t3b");

    // T4: bad keys accumulate into lockout
    for (int i = 1; i <= 3; i++) begin
      do_req(1'b0, 32'd10, 16'h0000, 32'd0, 1'b1, 2, "t4_bad_lat");
      check("t4_fail_count", 32'(fail_count), 32'(i));
    end
    push(1'b0, 1'b0, 32'd42);
    drive(1'b0, 32'd10, KEY);
    n = 0;
    rdy = 0;
    @(negedge clk);
    while (locked && n < 40) begin
      if (mem_req_ready) rdy++;
      n++;
      @(negedge clk);
    end
    check("t4_lock_cycles", 32'(n), 32'd16);
    check("t4_lock_ready", 32'(rdy), 32'd0);
    check("t4_fail_clear", 32'(fail_count), 32'd0);
    wait_accept(1'b0);
    wait_rsp("t4_after_lat", 4);
    @(posedge clk); #1;

    // T5: back-pressure holds the response and blocks the other side
    rsp_ready = 1'b0;
    push(1'b0, 1'b0, 32'd42);
    drive(1'b0, 32'd10, KEY);
    @(negedge clk);
    wait_accept(1'b0);
    push(1'b1, 1'b0, 32'hFFFF_FFFF);
    drive(1'b1, 32'd30, KEY);
    wait_rsp("t5_lat", 4);
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", 32'(rsp_valid), 32'd1);
      check("t5_hold_data", rsp_data, 32'd42);
      check("t5_reg_blocked", 32'(reg_req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    wait_accept(1'b1);
    wait_rsp("t5_reg_lat", 4);
    @(posedge clk); #1;

    // T6: reset during EXEC aborts the request and clears state
    do_req(1'b1, 32'd30, 16'h1234, 32'd0, 1'b1, 2, "t6_bad_lat");
    check("t6_fail_count", 32'(fail_count), 32'd1);
    drive(1'b0, 32'd10, KEY);
    @(negedge clk);
    wait_accept(1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_rsp_data", rsp_data, 32'd0);
    check("t6_rsp_src", 32'(rsp_src), 32'd0);
    check("t6_rsp_err", 32'(rsp_err), 32'd0);
    check("t6_locked", 32'(locked), 32'd0);
    check("t6_fail_count_rst", 32'(fail_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
    tie_round("t6_tie");

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
